// File: rtl/fios_pkg.sv
// Shared FIOS definitions: default operand geometry plus the state encodings
// used by the control FSM and by the result collector.
package fios_pkg;

    localparam int FIOS_S_DEFAULT = 16;
    localparam int FIOS_W_DEFAULT = 17;

    typedef enum logic [1:0] {
        CTRL_IDLE = 2'd0,
        CTRL_INIT = 2'd1,
        CTRL_LOOP = 2'd2,
        CTRL_DONE = 2'd3
    } fios_ctrl_state_e;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } fios_collect_state_e;

endpackage

// File: rtl/fios_result_out_reg.sv
// Output holding register with a valid/ready handshake. A new frame is accepted
// when the register is empty or is being drained in the same cycle.
module fios_result_out_reg #(
    parameter int DW = 272
) (
    input  logic          clock_i,
    input  logic          reset_n_i,
    input  logic          load_i,
    input  logic [DW-1:0] data_i,
    input  logic          ready_i,
    output logic          valid_o,
    output logic [DW-1:0] data_o,
    output logic          drop_o
);

    logic          r_valid;
    logic [DW-1:0] r_data;
    logic          w_accept;

    assign w_accept = load_i && (!r_valid || ready_i);
    assign drop_o   = load_i && r_valid && !ready_i;

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_data  <= data_i;
        end else if (r_valid && ready_i) begin
            r_valid <= 1'b0;
        end
    end

    assign valid_o = r_valid;
    assign data_o  = r_data;

endmodule

// File: rtl/fios_result_collector.sv
// Gathers the LSW-first result words streamed out of the last PE into one
// s*W-bit result, double-buffered against the downstream consumer.
module fios_result_collector
    import fios_pkg::*;
#(
    parameter int s = FIOS_S_DEFAULT,
    parameter int W = FIOS_W_DEFAULT
) (
    input  logic           clock_i,
    input  logic           reset_n_i,
    input  logic           RES_push_i,
    input  logic [W-1:0]   RES_word_i,
    input  logic           done_i,
    input  logic           result_ready_i,
    output logic           result_valid_o,
    output logic [s*W-1:0] result_o,
    output logic           busy_o,
    output logic           overflow_o,
    output logic           frame_err_o
);

    localparam int             CW   = $clog2(s + 1);
    localparam logic [CW-1:0]  LAST = CW'(s - 1);

    fios_collect_state_e r_state;
    logic [CW-1:0]       r_cnt;
    logic [s*W-1:0]      r_buf;
    logic                r_overflow;
    logic                r_frame_err;

    logic [CW-1:0]       w_idx;
    logic [s*W-1:0]      w_frame;
    logic                w_complete;
    logic                w_frame_err;
    logic                w_drop;

    // A push seen in IDLE always starts a new frame at word 0.
    assign w_idx       = (r_state == ST_IDLE) ? '0 : r_cnt;
    assign w_complete  = RES_push_i && (w_idx == LAST);
    assign w_frame_err = done_i && !w_complete;

    // The completing word is merged combinationally so the whole frame can be
    // handed to the output register in the same cycle it arrives.
    always_comb begin
        w_frame = r_buf;
        w_frame[int'(w_idx) * W +: W] = RES_word_i;
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_buf       <= '0;
            r_overflow  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_frame_err) begin
                r_frame_err <= 1'b1;
                r_state     <= ST_IDLE;
                r_cnt       <= '0;
            end else if (RES_push_i) begin
                r_buf <= w_frame;
                if (w_complete) begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end else begin
                    r_state <= ST_COLLECT;
                    r_cnt   <= w_idx + CW'(1);
                end
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    fios_result_out_reg #(
        .DW (s * W)
    ) u_out_reg (
        .clock_i   (clock_i),
        .reset_n_i (reset_n_i),
        .load_i    (w_complete),
        .data_i    (w_frame),
        .ready_i   (result_ready_i),
        .valid_o   (result_valid_o),
        .data_o    (result_o),
        .drop_o    (w_drop)
    );

    assign busy_o      = (r_state == ST_COLLECT);
    assign overflow_o  = r_overflow;
    assign frame_err_o = r_frame_err;

endmodule

// File: tb/tb_fios_result_collector.sv
// Directed, table-driven bench for fios_result_collector with s=4, W=17.
module tb_fios_result_collector;

    localparam int S  = 4;
    localparam int W  = 17;
    localparam int RW = S * W;

    logic          clk;
    logic          rst_n;
    logic          push;
    logic [W-1:0]  word;
    logic          done;
    logic          ready;
    logic          valid;
    logic [RW-1:0] result;
    logic          busy;
    logic          ovf;
    logic          ferr;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic          push;
        logic [W-1:0]  word;
        logic          done;
        logic          ready;
        logic          ev;
        logic [RW-1:0] er;
        logic          eb;
        logic          eo;
        logic          ee;
    } vec_t;

    vec_t vq[$];

    fios_result_collector #(.s(S), .W(W)) dut (
        .clock_i        (clk),
        .reset_n_i      (rst_n),
        .RES_push_i     (push),
        .RES_word_i     (word),
        .done_i         (done),
        .result_ready_i (ready),
        .result_valid_o (valid),
        .result_o       (result),
        .busy_o         (busy),
        .overflow_o     (ovf),
        .frame_err_o    (ferr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [RW-1:0] pack(int w0, int w1, int w2, int w3);
        return {W'(w3), W'(w2), W'(w1), W'(w0)};
    endfunction

    function automatic vec_t mk(logic p, int wd, logic d, logic r,
                                logic ev, logic [RW-1:0] er, logic eb, logic eo, logic ee);
        vec_t v;
        v.push = p;  v.word = W'(wd); v.done = d; v.ready = r;
        v.ev = ev;   v.er = er;       v.eb = eb;  v.eo = eo;  v.ee = ee;
        return v;
    endfunction

    task automatic chk(string name, logic [RW-1:0] act, logic [RW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outs(string tag, logic ev, logic [RW-1:0] er, logic eb, logic eo, logic ee);
        chk({tag, " valid"},     RW'(valid), RW'(ev));
        chk({tag, " result"},    result,     er);
        chk({tag, " busy"},      RW'(busy),  RW'(eb));
        chk({tag, " overflow"},  RW'(ovf),   RW'(eo));
        chk({tag, " frame_err"}, RW'(ferr),  RW'(ee));
    endtask

    task automatic apply(vec_t v, string tag);
        push  = v.push;
        word  = v.word;
        done  = v.done;
        ready = v.ready;
        @(posedge clk);
        #1;
        check_outs(tag, v.ev, v.er, v.eb, v.eo, v.ee);
    endtask

    initial begin
        logic [RW-1:0] r1, ra, rb, r3, r4, r5;
        r1 = pack(1, 2, 3, 4);
        ra = pack(9, 10, 11, 12);
        rb = pack(5, 6, 7, 8);
        r3 = pack(31, 32, 33, 34);
        r4 = pack(41, 42, 43, 44);
        r5 = pack(51, 52, 53, 54);

        // basic frame, ready held high
        vq.push_back(mk(1, 1, 0, 1, 0, '0, 1, 0, 0));
        vq.push_back(mk(1, 2, 0, 1, 0, '0, 1, 0, 0));
        vq.push_back(mk(1, 3, 0, 1, 0, '0, 1, 0, 0));
        vq.push_back(mk(1, 4, 1, 1, 1, r1, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 1, 0, r1, 0, 0, 0));
        // frame A parks in the output register
        vq.push_back(mk(1, 9,  0, 0, 0, r1, 1, 0, 0));
        vq.push_back(mk(1, 10, 0, 0, 0, r1, 1, 0, 0));
        vq.push_back(mk(1, 11, 0, 0, 0, r1, 1, 0, 0));
        vq.push_back(mk(1, 12, 1, 0, 1, ra, 0, 0, 0));
        // frame B completes while A drains: swap without overflow
        vq.push_back(mk(1, 5, 0, 0, 1, ra, 1, 0, 0));
        vq.push_back(mk(1, 6, 0, 0, 1, ra, 1, 0, 0));
        vq.push_back(mk(1, 7, 0, 0, 1, ra, 1, 0, 0));
        vq.push_back(mk(1, 8, 1, 1, 1, rb, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 1, rb, 0, 0, 0));
        // frame C completes with B unread: dropped, overflow sticks
        vq.push_back(mk(1, 13, 0, 0, 1, rb, 1, 0, 0));
        vq.push_back(mk(1, 14, 0, 0, 1, rb, 1, 0, 0));
        vq.push_back(mk(1, 15, 0, 0, 1, rb, 1, 0, 0));
        vq.push_back(mk(1, 16, 1, 0, 1, rb, 0, 1, 0));
        vq.push_back(mk(0, 0,  0, 1, 0, rb, 0, 1, 0));
        // early done after two words
        vq.push_back(mk(1, 21, 0, 0, 0, rb, 1, 1, 0));
        vq.push_back(mk(1, 22, 0, 0, 0, rb, 1, 1, 0));
        vq.push_back(mk(0, 0,  1, 0, 0, rb, 0, 1, 1));
        vq.push_back(mk(1, 31, 0, 0, 0, rb, 1, 1, 1));
        vq.push_back(mk(1, 32, 0, 0, 0, rb, 1, 1, 1));
        vq.push_back(mk(1, 33, 0, 0, 0, rb, 1, 1, 1));
        vq.push_back(mk(1, 34, 1, 1, 1, r3, 0, 1, 1));
        vq.push_back(mk(0, 0,  0, 1, 0, r3, 0, 1, 1));
        // gaps between words
        vq.push_back(mk(1, 41, 0, 0, 0, r3, 1, 1, 1));
        vq.push_back(mk(0, 0,  0, 0, 0, r3, 1, 1, 1));
        vq.push_back(mk(1, 42, 0, 0, 0, r3, 1, 1, 1));
        vq.push_back(mk(0, 0,  0, 0, 0, r3, 1, 1, 1));
        vq.push_back(mk(0, 0,  0, 0, 0, r3, 1, 1, 1));
        vq.push_back(mk(1, 43, 0, 0, 0, r3, 1, 1, 1));
        vq.push_back(mk(0, 0,  0, 0, 0, r3, 1, 1, 1));
        vq.push_back(mk(1, 44, 1, 0, 1, r4, 0, 1, 1));
        vq.push_back(mk(0, 0,  0, 1, 0, r4, 0, 1, 1));

        rst_n = 1'b0;
        push  = 1'b0;
        word  = '0;
        done  = 1'b0;
        ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_outs("reset", 0, '0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            apply(vq[i], $sformatf("vec%0d", i));
        end

        // reset in the middle of a frame, between clock edges
        apply(mk(1, 61, 0, 0, 0, r4, 1, 1, 1), "mid0");
        apply(mk(1, 62, 0, 0, 0, r4, 1, 1, 1), "mid1");
        apply(mk(1, 63, 0, 0, 0, r4, 1, 1, 1), "mid2");
        push = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_outs("async_rst", 0, '0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        apply(mk(1, 51, 0, 1, 0, '0, 1, 0, 0), "post0");
        apply(mk(1, 52, 0, 1, 0, '0, 1, 0, 0), "post1");
        apply(mk(1, 53, 0, 1, 0, '0, 1, 0, 0), "post2");
        apply(mk(1, 54, 1, 1, 1, r5, 0, 0, 0), "post3");
        apply(mk(0, 0,  0, 1, 0, r5, 0, 0, 0), "post4");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
